flash_cache_loader: RTL and testbench
=====================================

// Module: flash_cache_loader
// PURPOSE
//  Boot-time sequencer: reads TRANSFER_BYTES from SPI flash (cmd 0x03, 24-bit addr) and writes them as 32-bit words into Cache.
//  Sits between the flash pins and the cache request port.
//  Owns the cache port while busy; a host side takes the port after done.
//  Runs in the sys_clk domain.
// PARAMETERS
//  FLASH_START_ADDRESS  24'h000000    first flash byte address sent after cmd 0x03
//  CACHE_START_ADDRESS  32'h00000000  cache byte address of first word
//  TRANSFER_BYTES       32'h00010000  bytes to copy; nonzero multiple of 4 (elaboration $error otherwise)
//  STARTUP_WAIT         10            clk cycles between start and CS assertion (flash power-up)
//  SCK_HALF_CYCLES      1             clk cycles per flash_clk phase (>=1)
// PORTS
//  clk                 in   1   sys_clk (27 MHz)
//  rst_n               in   1   asynchronous, active-low reset
//  start               in   1   1-cycle pulse; begins a transfer when not busy
//  busy                out  1   high from cycle after accepted start until done
//  done                out  1   level; high after last cache write completes, cleared by next accepted start
//  flash_clk           out  1   SPI SCK, mode 0
//  flash_mosi          out  1   SPI MOSI
//  flash_miso          in   1   SPI MISO
//  flash_cs            out  1   SPI CS, active low
//  cache_address       out  32  byte address of word being written
//  cache_data_in       out  32  word; first flash byte of the group in [7:0]
//  cache_write_enable  out  4   4'b1111 during write request, else 0
//  cache_busy          in   1   cache busy; valid 1 cycle after write_enable rises
// BEHAVIOUR
//  Reset (async, immediate): flash_cs=1, flash_clk=0, flash_mosi=0, cache_write_enable=0, cache_address=0, cache_data_in=0, busy=0, done=0, state=IDLE.
//  States and transitions:
//   IDLE: start -> POWER_WAIT, busy=1, done=0, counter=0.
//   POWER_WAIT: after STARTUP_WAIT cycles -> SEND_CMD; flash_cs=0.
//   SEND_CMD: shift 8'h03, MSB first -> SEND_ADDR.
//   SEND_ADDR: shift FLASH_START_ADDRESS, 24 bits, MSB first -> READ.
//   READ: clock in 4 bytes MSB first -> WRITE_REQ.
//   WRITE_REQ: 1 cycle; outputs are driven as below -> WRITE_WAIT.
//   WRITE_WAIT: on cache_busy==0, write_enable=0 and cache_address+=4.
//    Goes to DONE if TRANSFER_BYTES bytes are written, else READ.
//   DONE: flash_cs=1, busy=0, done=1 -> IDLE (done stays high).
//  WRITE_REQ outputs:
//   cache_address = CACHE_START_ADDRESS + 4*word_index.
//   cache_data_in = {b3,b2,b1,b0}.
//   cache_write_enable = 4'b1111.
//  SPI bit timing (per bit): low phase then high phase, each SCK_HALF_CYCLES clk.
//   Low phase entry: flash_clk=0 and MOSI updated.
//   High phase entry: flash_clk=1 and MISO sampled into shift register.
//   Default is 2 clk per bit, so one byte = 16 clk.
//  flash_mosi=0 during READ.
//  flash_clk stays 0 through WRITE_REQ/WRITE_WAIT with CS held low.
//   The flash read stream pauses and resumes with the next byte; no re-command.
//  Addresses: cache_address wraps mod 2^32. Flash addressing is the flash's auto-increment (wraps at 2^24).
//  start ignored while busy.
//  start in the same cycle DONE->IDLE is ignored. start in IDLE with done=1 restarts from parameters.
//  Byte counter is 32-bit; completion compare uses bytes_written == TRANSFER_BYTES (no overflow for legal values).
//  Reset mid-transfer aborts at once: CS deasserts, write_enable drops, done stays 0; no partial-word write.
// TESTING
//  1. Reset, start, TRANSFER_BYTES=8, flash model returns 12 34 56 78 9A BC DE F0.
//     -> two writes {78563412}@0 then {F0DEBC9A}@4, done=1, flash_cs=1.
//  2. Check MOSI stream after CS falls.
//     -> 03 then 000000 MSB first; 32 flash_clk rising edges before first data sample; 16 clk per byte.
//  3. cache_busy held high 5 cycles per write.
//     -> write_enable stays 4'b1111 with stable address/data; flash_clk stays 0 during stall; no bytes lost.
//  4. rst_n low during byte 2 of word 1, then release.
//     -> flash_cs=1, write_enable=0, busy=0, done=0 the same cycle; next start re-sends 03+address from scratch.
//  5. start pulses during busy, then start after done.
//     -> extra pulses ignored (exactly 2 writes); second run repeats identical writes, done clears then sets.
//  6. CACHE_START_ADDRESS=32'hFFFFFFFC, 8 bytes.
//     -> writes at FFFFFFFC then 00000000.

Source files
------------

// File: rtl/flash_cache_loader.sv
// flash_cache_loader: boot copy of SPI flash (cmd 03) into cache words; ports: clk/rst_n, start/busy/done control, mode-0 SPI pins, 32-bit cache write port with cache_busy handshake
module flash_cache_loader #(
  parameter logic [23:0] FLASH_START_ADDRESS = 24'h000000,
  parameter logic [31:0] CACHE_START_ADDRESS = 32'h00000000,
  parameter logic [31:0] TRANSFER_BYTES      = 32'h00010000,
  parameter int unsigned STARTUP_WAIT        = 10,
  parameter int unsigned SCK_HALF_CYCLES     = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        flash_clk,
  output logic        flash_mosi,
  input  logic        flash_miso,
  output logic        flash_cs,
  output logic [31:0] cache_address,
  output logic [31:0] cache_data_in,
  output logic [3:0]  cache_write_enable,
  input  logic        cache_busy
);
  if (TRANSFER_BYTES == 32'd0 || TRANSFER_BYTES[1:0] != 2'd0) begin : g_bad_len
    $error("TRANSFER_BYTES must be a nonzero multiple of 4");
  end
  if (SCK_HALF_CYCLES < 1) begin : g_bad_sck
    $error("SCK_HALF_CYCLES must be at least 1");
  end
  typedef enum logic [2:0] {IDLE, POWER_WAIT, SEND_CMD, SEND_ADDR, READ, WRITE_REQ, WRITE_WAIT, DONE} state_t;
  localparam logic [31:0] TX_INIT = {8'h03, FLASH_START_ADDRESS};
  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d, tx_q, tx_d, rx_q, rx_d, addr_q, addr_d, data_q, data_d, bytes_q, bytes_d;
  logic [4:0]  bit_q, bit_d;
  logic        sck_q, sck_d, mosi_q, mosi_d, cs_q, cs_d, we_q, we_d, busy_q, busy_d, done_q, done_d;
  logic        half_end, last_bit;
  assign half_end = cnt_q + 32'd1 >= SCK_HALF_CYCLES;
  assign last_bit = bit_q == (state_q == SEND_CMD ? 5'd7 : state_q == SEND_ADDR ? 5'd23 : 5'd31);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    addr_d  = addr_q;
    data_d  = data_q;
    bytes_d = bytes_q;
    bit_d   = bit_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    cs_d    = cs_q;
    we_d    = we_q;
    busy_d  = busy_q;
    done_d  = done_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = POWER_WAIT;
        busy_d  = 1'b1;
        done_d  = 1'b0;
        cnt_d   = '0;
        addr_d  = CACHE_START_ADDRESS;
        bytes_d = '0;
      end
      POWER_WAIT: if (cnt_q + 32'd1 >= STARTUP_WAIT) begin
        state_d = SEND_CMD;
        cs_d    = 1'b0;
        cnt_d   = '0;
        bit_d   = '0;
        tx_d    = TX_INIT;
        mosi_d  = TX_INIT[31];
      end else cnt_d = cnt_q + 32'd1;
      SEND_CMD, SEND_ADDR, READ: if (!half_end) cnt_d = cnt_q + 32'd1;
      else begin
        cnt_d = '0;
        sck_d = !sck_q;
        if (!sck_q) rx_d = {rx_q[30:0], flash_miso};
        else begin
          // command/address bits shift out of tx_q; zeros fill in, so MOSI idles low once they are gone
          bit_d  = last_bit ? 5'd0 : bit_q + 5'd1;
          tx_d   = tx_q << 1;
          mosi_d = tx_q[30];
          if (last_bit) begin
            state_d = state_q == SEND_CMD ? SEND_ADDR : state_q == SEND_ADDR ? READ : WRITE_REQ;
            we_d    = state_q == READ;
            data_d  = state_q == READ ? {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]} : data_q;
          end
        end
      end
      WRITE_REQ: state_d = WRITE_WAIT;
      WRITE_WAIT: if (!cache_busy) begin
        we_d    = 1'b0;
        addr_d  = addr_q + 32'd4;
        bytes_d = bytes_q + 32'd4;
        cnt_d   = '0;
        state_d = bytes_q + 32'd4 == TRANSFER_BYTES ? DONE : READ;
        cs_d    = bytes_q + 32'd4 == TRANSFER_BYTES;
        busy_d  = bytes_q + 32'd4 != TRANSFER_BYTES;
        done_d  = bytes_q + 32'd4 == TRANSFER_BYTES;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      bytes_q <= '0;
      bit_q   <= '0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      cs_q    <= 1'b1;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      bytes_q <= bytes_d;
      bit_q   <= bit_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      cs_q    <= cs_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  assign busy               = busy_q;
  assign done               = done_q;
  assign flash_clk          = sck_q;
  assign flash_mosi         = mosi_q;
  assign flash_cs           = cs_q;
  assign cache_address      = addr_q;
  assign cache_data_in      = data_q;
  assign cache_write_enable = we_q ? 4'hF : 4'h0;
endmodule

// File: tb/tb_flash_cache_loader.sv
// tb_flash_cache_loader: randomized scoreboard bench with a byte-array flash model and stalling cache model
module tb_flash_cache_loader;
  localparam logic [23:0] FSA = 24'hFFFFFC;
  localparam logic [31:0] CSA = 32'hFFFFFFF8;
  localparam int NB = 16;
  localparam int SW = 10;
  localparam int T = 10;
  logic clk = 0, rst_n = 1, start = 0, flash_miso = 0, cache_busy = 0;
  logic busy, done, flash_clk, flash_mosi, flash_cs;
  logic [31:0] cache_address, cache_data_in;
  logic [3:0] cache_write_enable;
  int vectors = 0, errors = 0;
  logic [7:0] mem [256];
  logic [63:0] exp_q [$];
  int rises = 0;
  logic [31:0] mosi_cap = 0;
  time t_first = 0;
  int stall_mode = -1;
  int stall_cur = 0, left = 0, we_len = 0, writes = 0;
  logic we_prev = 0;
  logic [31:0] hold_a, hold_d;
  logic [63:0] e;
  logic [7:0] fb;

  flash_cache_loader #(
    .FLASH_START_ADDRESS(FSA), .CACHE_START_ADDRESS(CSA), .TRANSFER_BYTES(32'(NB)),
    .STARTUP_WAIT(SW), .SCK_HALF_CYCLES(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .flash_clk(flash_clk), .flash_mosi(flash_mosi), .flash_miso(flash_miso), .flash_cs(flash_cs),
    .cache_address(cache_address), .cache_data_in(cache_data_in),
    .cache_write_enable(cache_write_enable), .cache_busy(cache_busy)
  );

  always #(T/2) clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] flash_byte(input int k);
    logic [23:0] a;
    a = FSA + 24'(k);
    return mem[a[7:0]];
  endfunction

  // flash model: counts SCK rising edges per CS window, captures command/address, streams bytes after the 32nd edge
  always @(negedge flash_cs) begin
    rises = 0;
    mosi_cap = 0;
  end
  always @(posedge flash_clk) if (!flash_cs) begin
    rises++;
    if (rises <= 32) mosi_cap = {mosi_cap[30:0], flash_mosi};
    else check("mosi_low_in_read", 32'(flash_mosi), 32'd0);
    if (rises == 1) t_first = $time;
    if (rises == 9) check("clk_per_byte", 32'(($time - t_first) / T), 32'd16);
    if (rises == 32) check("mosi_cmd_addr", mosi_cap, {8'h03, FSA});
    if (rises == 33) check("first_sample_offset", 32'(($time - t_first) / T), 32'd64);
  end
  always @(negedge flash_clk) if (!flash_cs && rises >= 32) begin
    fb = flash_byte((rises - 32) / 8);
    flash_miso = fb[7 - (rises - 32) % 8];
  end

  // cache model + monitor: pops the scoreboard on each new write request and holds cache_busy for a chosen stall
  always @(negedge clk) begin
    if (!rst_n) begin
      we_prev = 0;
      cache_busy = 0;
    end else if (cache_write_enable != 4'h0) begin
      if (!we_prev) begin
        writes++;
        check("we_value", 32'(cache_write_enable), 32'hF);
        if (exp_q.size() == 0) check("write_expected", 32'(exp_q.size()), 32'd1);
        else begin
          e = exp_q.pop_front();
          check("write_addr", cache_address, e[63:32]);
          check("write_data", cache_data_in, e[31:0]);
        end
        hold_a = cache_address;
        hold_d = cache_data_in;
        stall_cur = stall_mode < 0 ? int'($urandom_range(0, 4)) : stall_mode;
        left = stall_cur;
        we_len = 1;
        cache_busy = 1;
      end else begin
        we_len++;
        check("hold_addr", cache_address, hold_a);
        check("hold_data", cache_data_in, hold_d);
        check("sck_in_write", 32'(flash_clk), 32'd0);
        cache_busy = left > 0;
        if (left > 0) left--;
      end
    end else begin
      if (we_prev) check("we_cycles", 32'(we_len), 32'(stall_cur + 2));
      cache_busy = 0;
    end
    we_prev = cache_write_enable != 4'h0;
  end

  task automatic push_expected();
    for (int i = 0; i < NB / 4; i++)
      exp_q.push_back({CSA + 32'(4 * i), flash_byte(4 * i + 3), flash_byte(4 * i + 2), flash_byte(4 * i + 1), flash_byte(4 * i)});
  endtask

  task automatic run(input bit noisy);
    int n, w0;
    w0 = writes;
    @(negedge clk);
    start = 1;
    push_expected();
    @(negedge clk);
    start = 0;
    check("busy_after_start", 32'(busy), 32'd1);
    check("done_cleared", 32'(done), 32'd0);
    n = 0;
    while (flash_cs && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("startup_wait", 32'(n), 32'(SW));
    n = 0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
      if (!done) start = noisy && $urandom_range(0, 9) == 0;
    end
    check("done_set", 32'(done), 32'd1);
    check("busy_at_done", 32'(busy), 32'd0);
    check("cs_at_done", 32'(flash_cs), 32'd1);
    check("write_count", 32'(writes - w0), 32'(NB / 4));
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    check("start_in_done_ignored", 32'(busy), 32'd0);
    check("done_held", 32'(done), 32'd1);
  endtask

  initial begin
    logic [7:0] t1 [8];
    logic [7:0] a8;
    int n, w0;
    t1 = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    foreach (mem[i]) mem[i] = 8'($urandom);
    for (int i = 0; i < 8; i++) begin
      a8 = FSA[7:0] + 8'(i);
      mem[a8] = t1[i];
    end
    #2 rst_n = 0;
    #1;
    check("rst_cs", 32'(flash_cs), 32'd1);
    check("rst_sck", 32'(flash_clk), 32'd0);
    check("rst_mosi", 32'(flash_mosi), 32'd0);
    check("rst_we", 32'(cache_write_enable), 32'd0);
    check("rst_addr", cache_address, 32'd0);
    check("rst_data", cache_data_in, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1;
    stall_mode = -1;
    run(1'b1);
    stall_mode = 5;
    run(1'b1);
    stall_mode = -1;
    @(negedge clk);
    start = 1;
    push_expected();
    @(negedge clk);
    start = 0;
    w0 = writes;
    n = 0;
    while (flash_cs && n < 100) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (rises < 44 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("abort_point_reached", 32'(rises >= 44), 32'd1);
    rst_n = 0;
    #1;
    check("abort_cs", 32'(flash_cs), 32'd1);
    check("abort_we", 32'(cache_write_enable), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_no_write", 32'(writes - w0), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1;
    foreach (mem[i]) mem[i] = 8'($urandom);
    run(1'b1);
    run(1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
